// File: rtl/stream_crossbar_pkg.sv
// Shared types and helpers for the stream crossbar slave-side mux.
package stream_crossbar_pkg;

  // Slave-port ownership: IDLE waits for a grant, LOCK owns one master until tlast.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } mux_state_t;

  // Width of a master index; never narrower than one bit so a single-master
  // configuration still has a legal tid/grant_id port.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Output stage for stream_slave_mux.
// STREAM_SLAVE_MUX_SKID_EN defined   : 2-entry skid buffer, ready taken from a flop.
// STREAM_SLAVE_MUX_SKID_EN undefined : single register, ready = !valid || downstream ready.
module stream_skid_buffer #(
  parameter int unsigned P_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [P_WIDTH-1:0] s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [P_WIDTH-1:0] m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i
);

  logic               r_valid;
  logic [P_WIDTH-1:0] r_data;
  logic               w_out_free;

  assign w_out_free = !r_valid || m_ready_i;
  assign m_valid_o  = r_valid;
  assign m_data_o   = r_data;

`ifdef STREAM_SLAVE_MUX_SKID_EN
  logic               r_skid_valid;
  logic [P_WIDTH-1:0] r_skid_data;
  logic               w_in_hs;

  // Ready depends only on the skid flop, so upstream sees no combinational path from m_ready_i.
  assign s_ready_o = !r_skid_valid;
  assign w_in_hs   = s_valid_i && !r_skid_valid;

  // Output register refills from the skid entry first; a beat accepted while stalled parks in the skid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_data       <= r_skid_data;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_valid <= w_in_hs;
        if (w_in_hs) begin
          r_data <= s_data_i;
        end
      end
    end else if (w_in_hs) begin
      r_skid_data  <= s_data_i;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign s_ready_o = w_out_free;

  // Single pipeline register: load whenever the slot is empty or being drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_out_free) begin
      r_valid <= s_valid_i;
      if (s_valid_i) begin
        r_data <= s_data_i;
      end
    end
  end
`endif

endmodule

// File: rtl/stream_slave_mux.sv
// Slave-side packet mux: locks onto the arbiter-granted master for a whole
// packet and forwards its beats through a registered output stage.
// Optional feature macro: STREAM_SLAVE_MUX_SKID_EN (skid-buffer output stage).
module stream_slave_mux
  import stream_crossbar_pkg::*;
#(
  parameter  int unsigned S_DATA_COUNT = 2,
  parameter  int unsigned T_DATA_WIDTH = 8,
  localparam int unsigned T_ID___WIDTH = id_width(S_DATA_COUNT)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     grant_valid_i,
  input  logic [T_ID___WIDTH-1:0]                  grant_id_i,
  output logic [S_DATA_COUNT-1:0]                  last_o,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_tdata_i,
  input  logic [S_DATA_COUNT-1:0]                  s_tvalid_i,
  input  logic [S_DATA_COUNT-1:0]                  s_tlast_i,
  output logic [S_DATA_COUNT-1:0]                  s_tready_o,
  output logic [T_DATA_WIDTH-1:0]                  m_tdata_o,
  output logic                                     m_tvalid_o,
  output logic                                     m_tlast_o,
  output logic [T_ID___WIDTH-1:0]                  m_tid_o,
  input  logic                                     m_tready_i
);

  localparam int unsigned P_W = T_ID___WIDTH + 1 + T_DATA_WIDTH;

  mux_state_t              r_state;
  logic [T_ID___WIDTH-1:0] r_locked_id;

  logic           w_lock;
  logic           w_in_valid;
  logic           w_buf_ready;
  logic           w_in_hs;
  logic           w_in_last_hs;
  logic           w_grant_ok;
  logic [P_W-1:0] w_in_payload;
  logic [P_W-1:0] w_out_payload;

  assign w_lock       = (r_state == LOCK);
  assign w_in_valid   = w_lock && s_tvalid_i[r_locked_id];
  assign w_in_hs      = w_in_valid && w_buf_ready;
  assign w_in_last_hs = w_in_hs && s_tlast_i[r_locked_id];
  assign w_grant_ok   = grant_valid_i && (32'(grant_id_i) < S_DATA_COUNT);
  assign w_in_payload = {r_locked_id, s_tlast_i[r_locked_id], s_tdata_i[r_locked_id]};

  // Route the output-stage ready and the end-of-packet flag to the locked master only.
  always_comb begin
    s_tready_o = '0;
    last_o     = '0;
    if (w_lock) begin
      s_tready_o[r_locked_id] = w_buf_ready;
      last_o[r_locked_id]     = w_in_last_hs;
    end
  end

  // Ownership FSM: capture a valid grant in IDLE, release on the tlast handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_locked_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_ok) begin
            r_locked_id <= grant_id_i;
            r_state     <= LOCK;
          end
        end
        LOCK: begin
          if (w_in_last_hs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_skid_buffer #(
    .P_WIDTH(P_W)
  ) u_out (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_data_i  (w_in_payload),
    .s_valid_i (w_in_valid),
    .s_ready_o (w_buf_ready),
    .m_data_o  (w_out_payload),
    .m_valid_o (m_tvalid_o),
    .m_ready_i (m_tready_i)
  );

  assign {m_tid_o, m_tlast_o, m_tdata_o} = w_out_payload;

endmodule

// File: tb/tb_stream_slave_mux.sv
// Scoreboard bench for stream_slave_mux (S_DATA_COUNT=3, T_DATA_WIDTH=8).
module tb_stream_slave_mux;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 grant_valid;
  logic [IW-1:0]        grant_id;
  logic [N-1:0]         last_o;
  logic [N-1:0][W-1:0]  s_tdata;
  logic [N-1:0]         s_tvalid;
  logic [N-1:0]         s_tlast;
  logic [N-1:0]         s_tready;
  logic [W-1:0]         m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic [IW-1:0]        m_tid;
  logic                 m_tready;

  always #5 clk = ~clk;

  stream_slave_mux #(
    .S_DATA_COUNT(N),
    .T_DATA_WIDTH(W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .grant_valid_i(grant_valid),
    .grant_id_i   (grant_id),
    .last_o       (last_o),
    .s_tdata_i    (s_tdata),
    .s_tvalid_i   (s_tvalid),
    .s_tlast_i    (s_tlast),
    .s_tready_o   (s_tready),
    .m_tdata_o    (m_tdata),
    .m_tvalid_o   (m_tvalid),
    .m_tlast_o    (m_tlast),
    .m_tid_o      (m_tid),
    .m_tready_i   (m_tready)
  );

  typedef struct {
    logic [IW-1:0] tid;
    logic          last;
    logic [W-1:0]  data;
    int            in_cyc;
  } beat_t;

  beat_t sb[$];
  int    out_cyc_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    exp_master = 0;
  bit    lat_chk = 1'b0;

  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic          prev_rst = 1'b1;
  logic [W-1:0]  prev_d = '0;
  logic          prev_l = 1'b0;
  logic [IW-1:0] prev_id = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Input side: every accepted beat becomes an expected output beat.
  always @(negedge clk) begin
    logic [N-1:0] exp_last;
    exp_last = '0;
    if (rst === 1'b0) begin
      for (int i = 0; i < int'(N); i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          chk("accept_master", i, exp_master);
          sb.push_back('{tid: IW'(exp_master), last: s_tlast[i], data: s_tdata[i], in_cyc: cyc});
          if (s_tlast[i]) exp_last[exp_master] = 1'b1;
        end
      end
      chk("last_o", last_o, exp_last);
    end
  end

  // Output side: hold-stability and in-order beat comparison.
  always @(negedge clk) begin
    beat_t e;
    if (rst === 1'b0 && !prev_rst && prev_v && !prev_r) begin
      chk("hold_valid", m_tvalid, 1);
      chk("hold_data", m_tdata, prev_d);
      chk("hold_last", m_tlast, prev_l);
      chk("hold_tid", m_tid, prev_id);
    end
    if (rst === 1'b0 && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data=%0h tid=%0d want none", m_tdata, m_tid);
      end else begin
        e = sb.pop_front();
        chk("out_tid", m_tid, e.tid);
        chk("out_last", m_tlast, e.last);
        chk("out_data", m_tdata, e.data);
        if (lat_chk) chk("latency", cyc, e.in_cyc + 1);
        out_cyc_q.push_back(cyc);
      end
    end
    prev_v   = m_tvalid;
    prev_r   = m_tready;
    prev_rst = rst;
    prev_d   = m_tdata;
    prev_l   = m_tlast;
    prev_id  = m_tid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for master m's handshake; returns its cycle, leaves us just after that edge.
  task automatic wait_hs(input int m, output int c);
    bit got;
    got = 1'b0;
    c = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (s_tvalid[m] && s_tready[m]) begin
        got = 1'b1;
        c = cyc;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL hs_timeout: master %0d got no ready want ready within 60 cycles", m);
    end
    tick();
  endtask

  task automatic send_pkt(input int m, input int n, input logic [W-1:0] base,
                          output int first_hs, output int last_hs);
    int c;
    exp_master  = m;
    grant_valid = 1'b1;
    grant_id    = IW'(m);
    first_hs = -1;
    last_hs  = -1;
    for (int b = 0; b < n; b++) begin
      s_tvalid[m] = 1'b1;
      s_tdata[m]  = base + W'(b);
      s_tlast[m]  = (b == n - 1);
      wait_hs(m, c);
      if (b == 0) first_hs = c;
      last_hs = c;
      grant_valid = 1'b0;
    end
    s_tvalid[m] = 1'b0;
    s_tlast[m]  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, l0, f1, l1, c;
    rst = 1'b1; grant_valid = 1'b0; grant_id = '0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tid", m_tid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_last_o", last_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic packet from master 2.
    lat_chk = 1'b1;
    send_pkt(2, 3, 8'hA1, f0, l0);
    chk("pkt2_consecutive", l0 - f0, 2);
    drain();

    // Invalid grant id is ignored in IDLE.
    grant_valid = 1'b1; grant_id = 2'd3; s_tvalid[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("bad_grant_ready", s_tready, 0);
    grant_valid = 1'b0; s_tvalid[0] = 1'b0;
    tick();

    // Backpressure mid-packet.
    lat_chk = 1'b0;
    out_cyc_q.delete();
    fork
      send_pkt(2, 6, 8'h30, f0, l0);
      begin
        for (int k = 0; k < 60 && out_cyc_q.size() < 2; k++) @(negedge clk);
        tick();
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_m_tvalid", m_tvalid, 1);
`ifdef STREAM_SLAVE_MUX_SKID_EN
          if (k >= 1) chk("bp_ready_skid", s_tready[2], 0);
`else
          chk("bp_ready", s_tready[2], 0);
`endif
          tick();
        end
        m_tready = 1'b1;
      end
    join
    drain();
    chk("bp_beats", out_cyc_q.size(), 6);

    // Back-to-back packets: one IDLE cycle at the boundary.
    lat_chk = 1'b1;
    send_pkt(0, 2, 8'h10, f0, l0);
    send_pkt(1, 2, 8'h20, f1, l1);
    chk("idle_gap", f1 - l0, 2);
    drain();

    // Competing master 0 while master 1 owns the port.
    s_tvalid[0] = 1'b1; s_tdata[0] = 8'hEE;
    fork
      send_pkt(1, 3, 8'h50, f0, l0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("ready_mask", s_tready, 3'b010);
      end
    join
    s_tvalid[0] = 1'b0;
    drain();

    // Reset mid-packet discards the stalled beat.
    lat_chk = 1'b0;
    exp_master = 1; grant_valid = 1'b1; grant_id = 2'd1;
    s_tvalid[1] = 1'b1; s_tdata[1] = 8'hC0; s_tlast[1] = 1'b0;
    wait_hs(1, c);
    grant_valid = 1'b0; s_tdata[1] = 8'hC1;
    wait_hs(1, c);
    m_tready = 1'b0; rst = 1'b1; s_tvalid[1] = 1'b0;
    tick();
    sb.delete();
    rst = 1'b0; m_tready = 1'b1;
    s_tvalid[0] = 1'b1; s_tdata[0] = 8'h99;
    @(negedge clk);
    chk("post_rst_m_tvalid", m_tvalid, 0);
    chk("post_rst_m_tdata", m_tdata, 0);
    chk("post_rst_last_o", last_o, 0);
    chk("post_rst_idle_ready", s_tready, 0);
    s_tvalid[0] = 1'b0;
    tick();
    lat_chk = 1'b1;
    send_pkt(1, 4, 8'hD0, f0, l0);
    drain();

    // Long packet at full rate.
    out_cyc_q.delete();
    send_pkt(0, 16, 8'h80, f0, l0);
    drain();
    tick();
    chk("long_beats", out_cyc_q.size(), 16);
    if (out_cyc_q.size() == 16) chk("long_span", out_cyc_q[15] - out_cyc_q[0], 15);
    chk("long_in_span", l0 - f0, 15);

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
